// File: rtl/regfile_pkg.sv
// Shared sizing and constants for the register file and its pending-write scoreboard.
// Optional feature macro used by the top: REGFILE_WRITE_THROUGH_EN.
package regfile_pkg;
    localparam int NREG  = 32;
    localparam int DW    = 32;
    localparam int CNT_W = 2;
    localparam int AW    = $clog2(NREG);

    localparam logic [AW-1:0]    R0_IDX  = '0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// One register's pending-write counter: counts in-flight writes between issue and
// write-back. It never wraps, and flush drops every in-flight claim.
module sb_counter
    import regfile_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             flush,
    output logic [CNT_W-1:0] cnt,
    output logic             busy
);

    // An issue and a retire on the same cycle cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// GPR file with a pending-write scoreboard that stalls RAW reads and throttles claims.
// Macro REGFILE_WRITE_THROUGH_EN forwards the retiring WB value to same-cycle reads.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rf_raddr1,
    input  logic [AW-1:0]   rf_raddr2,
    output logic [DW-1:0]   rf_rdata1,
    output logic [DW-1:0]   rf_rdata2,
    input  logic            issue_valid,
    input  logic            issue_we,
    input  logic [AW-1:0]   issue_waddr,
    output logic            issue_ready,
    input  logic            wb_valid,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_waddr,
    input  logic [DW-1:0]   wb_wdata,
    input  logic            flush,
    output logic            raw_stall,
    output logic [NREG-1:0] busy
);

    // Issue handshake: a claim is taken only on a cycle where issue_valid and
    // issue_ready are both high. issue_ready depends only on the counter of the
    // addressed register and issue_we/issue_waddr, never on issue_valid. A held
    // claim can be dropped by its producer; flush discards the claim of its cycle.
    logic            issue_fire;
    logic            wb_fire;
    logic [DW-1:0]   regs [NREG];
    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0] busy_eff;

    assign wb_fire    = wb_valid && wb_we && (wb_waddr != R0_IDX);
    assign issue_fire = issue_valid && issue_we && (issue_waddr != R0_IDX) && issue_ready;

    assign issue_ready = (cnt[issue_waddr] != CNT_MAX) || !issue_we || (issue_waddr == R0_IDX);

    assign cnt[0]  = '0;
    assign busy[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_cnt
        sb_counter u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (issue_fire && (issue_waddr == AW'(i))),
            .dec   (wb_fire && (wb_waddr == AW'(i))),
            .flush (flush),
            .cnt   (cnt[i]),
            .busy  (busy[i])
        );
    end

    // r0 is never written because wb_fire excludes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_fire) begin
            regs[wb_waddr] <= wb_wdata;
        end
    end

`ifdef REGFILE_WRITE_THROUGH_EN
    logic bypass1;
    logic bypass2;

    assign bypass1 = wb_fire && (rf_raddr1 == wb_waddr);
    assign bypass2 = wb_fire && (rf_raddr2 == wb_waddr);

    assign rf_rdata1 = (rf_raddr1 == R0_IDX) ? '0 : (bypass1 ? wb_wdata : regs[rf_raddr1]);
    assign rf_rdata2 = (rf_raddr2 == R0_IDX) ? '0 : (bypass2 ? wb_wdata : regs[rf_raddr2]);

    // The last outstanding write is being forwarded, so its reader need not wait.
    always_comb begin
        busy_eff = busy;
        if (wb_fire && cnt[wb_waddr] == CNT_W'(1)) begin
            busy_eff[wb_waddr] = 1'b0;
        end
    end
`else
    assign rf_rdata1 = (rf_raddr1 == R0_IDX) ? '0 : regs[rf_raddr1];
    assign rf_rdata2 = (rf_raddr2 == R0_IDX) ? '0 : regs[rf_raddr2];
    assign busy_eff  = busy;
`endif

    assign raw_stall = ((rf_raddr1 != R0_IDX) && busy_eff[rf_raddr1]) ||
                       ((rf_raddr2 != R0_IDX) && busy_eff[rf_raddr2]);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: the driver pushes the expected outputs of each
// cycle, and a negedge monitor pops and compares them (REGFILE_WRITE_THROUGH_EN aware).
module tb_regfile_scoreboard;

`ifdef REGFILE_WRITE_THROUGH_EN
    localparam bit WT = 1'b1;
`else
    localparam bit WT = 1'b0;
`endif

    localparam logic [4:0] M_RD1   = 5'b00001;
    localparam logic [4:0] M_RD2   = 5'b00010;
    localparam logic [4:0] M_BUSY  = 5'b00100;
    localparam logic [4:0] M_STALL = 5'b01000;
    localparam logic [4:0] M_READY = 5'b10000;
    localparam logic [4:0] M_ALL   = 5'b11111;

    typedef struct packed {
        logic [7:0]  id;
        logic [4:0]  mask;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] bsy;
        logic        stall;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];

    logic        clk;
    logic        reset;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        issue_valid, issue_we;
    logic [4:0]  issue_waddr;
    logic        issue_ready;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        flush;
    logic        raw_stall;
    logic [31:0] busy;

    int checks = 0;
    int errors = 0;
    int step_id = 0;

    regfile_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_waddr (issue_waddr),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_we       (wb_we),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .flush       (flush),
        .raw_stall   (raw_stall),
        .busy        (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic drv(input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic iv, input logic iwe, input logic [4:0] iwa,
                       input logic wv, input logic wwe, input logic [4:0] wwa,
                       input logic [31:0] wwd, input logic fl);
        @(posedge clk);
        #1;
        rf_raddr1   = ra1;
        rf_raddr2   = ra2;
        issue_valid = iv;
        issue_we    = iwe;
        issue_waddr = iwa;
        wb_valid    = wv;
        wb_we       = wwe;
        wb_waddr    = wwa;
        wb_wdata    = wwd;
        flush       = fl;
        step_id++;
    endtask

    task automatic push(input logic [4:0] mask, input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] bsy, input logic stall, input logic rdy);
        exp_t e;
        e.id    = 8'(step_id);
        e.mask  = mask;
        e.rd1   = rd1;
        e.rd2   = rd2;
        e.bsy   = bsy;
        e.stall = stall;
        e.rdy   = rdy;
        exp_q.push_back(e);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.mask[0]) begin
                checks++;
                if (rf_rdata1 !== e.rd1) begin
                    errors++;
                    $display("FAIL step%0d rdata1: got %h expected %h", e.id, rf_rdata1, e.rd1);
                end
            end
            if (e.mask[1]) begin
                checks++;
                if (rf_rdata2 !== e.rd2) begin
                    errors++;
                    $display("FAIL step%0d rdata2: got %h expected %h", e.id, rf_rdata2, e.rd2);
                end
            end
            if (e.mask[2]) begin
                checks++;
                if (busy !== e.bsy) begin
                    errors++;
                    $display("FAIL step%0d busy: got %h expected %h", e.id, busy, e.bsy);
                end
            end
            if (e.mask[3]) begin
                checks++;
                if (raw_stall !== e.stall) begin
                    errors++;
                    $display("FAIL step%0d raw_stall: got %b expected %b", e.id, raw_stall, e.stall);
                end
            end
            if (e.mask[4]) begin
                checks++;
                if (issue_ready !== e.rdy) begin
                    errors++;
                    $display("FAIL step%0d issue_ready: got %b expected %b", e.id, issue_ready, e.rdy);
                end
            end
        end
    end

    // directed stimulus
    initial begin
        reset = 1'b1;
        rf_raddr1 = '0; rf_raddr2 = '0;
        issue_valid = 1'b0; issue_we = 1'b0; issue_waddr = '0;
        wb_valid = 1'b0; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset state, read r5
        drv(5, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        push(M_ALL, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

        // issue r3, retire DEADBEEF next cycle
        drv(3, 0, 1, 1, 3, 0, 0, 0, 32'h0, 0);
        push(M_BUSY | M_STALL | M_READY, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        drv(3, 0, 0, 0, 0, 1, 1, 3, 32'hDEADBEEF, 0);
        push(M_RD1 | M_BUSY | M_STALL, WT ? 32'hDEADBEEF : 32'h0, 32'h0,
             32'h0000_0008, WT ? 1'b0 : 1'b1, 1'b1);
        drv(3, 3, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        push(M_ALL, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);

        // r7 saturates at three claims
        drv(0, 7, 1, 1, 7, 0, 0, 0, 32'h0, 0);
        push(M_BUSY | M_STALL | M_READY, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        drv(0, 7, 1, 1, 7, 0, 0, 0, 32'h0, 0);
        push(M_BUSY | M_STALL | M_READY, 32'h0, 32'h0, 32'h0000_0080, 1'b1, 1'b1);
        drv(0, 7, 1, 1, 7, 0, 0, 0, 32'h0, 0);
        push(M_BUSY | M_READY, 32'h0, 32'h0, 32'h0000_0080, 1'b1, 1'b1);
        drv(0, 7, 1, 1, 7, 0, 0, 0, 32'h0, 0);
        push(M_BUSY | M_READY, 32'h0, 32'h0, 32'h0000_0080, 1'b1, 1'b0);
        // retire while the fourth claim is still held back
        drv(0, 7, 1, 1, 7, 1, 1, 7, 32'h77, 0);
        push(M_READY, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        drv(0, 7, 0, 1, 7, 0, 0, 0, 32'h0, 0);
        push(M_BUSY | M_READY | M_RD2, 32'h0, 32'h77, 32'h0000_0080, 1'b1, 1'b1);
        drv(7, 0, 0, 0, 0, 1, 1, 7, 32'h70, 0);
        push(M_BUSY | M_RD1, WT ? 32'h70 : 32'h77, 32'h0, 32'h0000_0080, 1'b1, 1'b1);
        drv(7, 0, 0, 0, 0, 1, 1, 7, 32'h71, 0);
        push(M_BUSY | M_RD1, WT ? 32'h71 : 32'h70, 32'h0, 32'h0000_0080, 1'b1, 1'b1);
        // retire at cnt 0 must not underflow
        drv(7, 7, 0, 0, 0, 1, 1, 7, 32'h72, 0);
        push(M_BUSY | M_RD1 | M_STALL, WT ? 32'h72 : 32'h71, 32'h0, 32'h0, 1'b0, 1'b1);
        drv(7, 7, 0, 1, 7, 0, 0, 0, 32'h0, 0);
        push(M_ALL, 32'h72, 32'h72, 32'h0, 1'b0, 1'b1);

        // same-cycle issue and retire of r4 at cnt 1
        drv(0, 0, 1, 1, 4, 0, 0, 0, 32'h0, 0);
        push(M_BUSY, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        drv(4, 0, 1, 1, 4, 1, 1, 4, 32'hA5A5A5A5, 0);
        push(M_RD1 | M_BUSY | M_STALL | M_READY, WT ? 32'hA5A5A5A5 : 32'h0, 32'h0,
             32'h0000_0010, WT ? 1'b0 : 1'b1, 1'b1);
        drv(4, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        push(M_RD1 | M_BUSY | M_STALL, 32'hA5A5A5A5, 32'h0, 32'h0000_0010, 1'b1, 1'b1);
        drv(0, 0, 0, 0, 0, 1, 1, 4, 32'h44, 0);
        push(M_BUSY, 32'h0, 32'h0, 32'h0000_0010, 1'b0, 1'b1);
        drv(4, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        push(M_BUSY | M_RD1 | M_STALL, 32'h44, 32'h0, 32'h0, 1'b0, 1'b1);

        // flush with a WB in the same cycle; the issue to r11 is dropped
        drv(0, 0, 1, 1, 9, 0, 0, 0, 32'h0, 0);
        push(M_BUSY, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        drv(0, 0, 1, 1, 10, 0, 0, 0, 32'h0, 0);
        push(M_BUSY, 32'h0, 32'h0, 32'h0000_0200, 1'b0, 1'b1);
        drv(9, 0, 1, 1, 11, 1, 1, 9, 32'h1234, 1);
        push(M_BUSY, 32'h0, 32'h0, 32'h0000_0600, 1'b1, 1'b1);
        drv(9, 11, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        push(M_ALL, 32'h1234, 32'h0, 32'h0, 1'b0, 1'b1);

        // r0: claim and write are both ignored
        drv(0, 0, 1, 1, 0, 1, 1, 0, 32'hFFFFFFFF, 0);
        push(M_ALL, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        push(M_ALL, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

        // asynchronous reset mid-operation
        drv(0, 0, 1, 1, 12, 1, 1, 5, 32'h55, 0);
        push(M_BUSY, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        drv(5, 12, 0, 1, 12, 0, 0, 0, 32'h0, 0);
        push(M_ALL, 32'h55, 32'h0, 32'h0000_1000, 1'b1, 1'b1);
        drv(5, 12, 0, 1, 12, 0, 0, 0, 32'h0, 0);
        reset = 1'b1;
        push(M_ALL, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        drv(5, 12, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        reset = 1'b0;
        push(M_ALL, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

        // bounded drain of the scoreboard
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
